// File: rtl/aud_prefetch_pkg.sv
// Shared state encodings and constants for the audio sample prefetcher.
package aud_prefetch_pkg;

    typedef logic [2:0] pf_state_t;

    localparam pf_state_t IDLE      = 3'd0;
    localparam pf_state_t FETCH_CHK = 3'd1;
    localparam pf_state_t REQ       = 3'd2;
    localparam pf_state_t HOLD      = 3'd3;
    localparam pf_state_t FLUSH     = 3'd4;

    localparam logic [15:0] SILENCE = 16'h0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with asynchronous head read so a pop can return data one cycle later.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    // Storage has no reset so it maps onto embedded memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/aud_sample_prefetch.sv
// Prefetches PCM samples from an SDRAM arbiter port into a FIFO feeding the I2S serializer.
module aud_sample_prefetch
    import aud_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned LOW_WATER   = 16,
    parameter int unsigned ACK_TIMEOUT = 4096
) (
    input  logic                   MAX10_CLK1_50,
    input  logic                   Reset_h,
    input  logic                   enable,
    input  logic [24:0]            addr_start,
    input  logic [24:0]            addr_end,
    input  logic                   loop_en,
    output logic                   ram_rden,
    output logic [24:0]            ram_addr,
    input  logic [15:0]            ram_data,
    input  logic                   ram_ack,
    input  logic                   smp_req,
    output logic [15:0]            smp_data,
    output logic                   smp_valid,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   low_water,
    output logic                   clip_done,
    output logic [15:0]            underrun_cnt,
    output logic                   ack_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    pf_state_t        state;
    pf_state_t        state_next;
    logic             enable_q;
    logic             abort;
    logic [24:0]      addr;
    logic [24:0]      addr_lo;
    logic [24:0]      addr_hi;
    logic [TW-1:0]    tmo_ctr;

    logic             start;
    logic             serving;
    logic             last_word;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic [15:0]      fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (MAX10_CLK1_50),
        .rst   (Reset_h),
        .push  (fifo_push),
        .din   (ram_data),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        start      = (state == IDLE) && enable && !enable_q;
        serving    = enable && ((state == FETCH_CHK) || (state == REQ) || (state == HOLD));
        last_word  = (addr >= addr_hi);
        // A request raced by enable falling still completes, but its data is dropped.
        fifo_push  = (state == REQ) && ram_ack && enable && !abort;
        fifo_pop   = smp_req && serving && !fifo_empty;
        fifo_flush = (state == FLUSH);
        ram_rden   = (state == REQ);
        ram_addr   = addr;
        fill_level = fifo_count;
        low_water  = (state != IDLE) && (fifo_count <= CW'(LOW_WATER));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = FETCH_CHK;
            FETCH_CHK: begin
                if (!enable)         state_next = FLUSH;
                else if (clip_done)  state_next = HOLD;
                else if (!fifo_full) state_next = REQ;
            end
            REQ:       if (ram_ack) state_next = (abort || !enable) ? FLUSH : FETCH_CHK;
            HOLD:      if (!enable) state_next = FLUSH;
            FLUSH:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            state        <= IDLE;
            enable_q     <= 1'b0;
            abort        <= 1'b0;
            addr         <= '0;
            addr_lo      <= '0;
            addr_hi      <= '0;
            tmo_ctr      <= '0;
            clip_done    <= 1'b0;
            ack_err      <= 1'b0;
            underrun_cnt <= '0;
            smp_data     <= SILENCE;
            smp_valid    <= 1'b0;
        end else begin
            state    <= state_next;
            enable_q <= enable;

            if (start) begin
                addr         <= addr_start;
                addr_lo      <= addr_start;
                addr_hi      <= addr_end;
                clip_done    <= 1'b0;
                underrun_cnt <= '0;
            end

            if (fifo_push) begin
                if (!last_word)   addr <= addr + 25'd1;
                else if (loop_en) addr <= addr_lo;
                else              clip_done <= 1'b1;
            end

            if (state == REQ) begin
                if (ram_ack) begin
                    abort   <= 1'b0;
                    tmo_ctr <= '0;
                end else begin
                    if (!enable) abort <= 1'b1;
                    if (tmo_ctr >= TW'(ACK_TIMEOUT - 1)) ack_err <= 1'b1;
                    if (tmo_ctr < TW'(ACK_TIMEOUT)) tmo_ctr <= tmo_ctr + TW'(1);
                end
            end

            smp_valid <= smp_req;
            if (smp_req) begin
                smp_data <= fifo_pop ? fifo_dout : SILENCE;
                if (serving && fifo_empty && (underrun_cnt != 16'hFFFF)) begin
                    underrun_cnt <= underrun_cnt + 16'd1;
                end
            end
        end
    end

endmodule
